// File: rtl/ptp_bridge_ewadj.sv
// Egress width adjust: serialises wide AXI-S beats into narrow beats, LSB bytes first.
// Optional macro PTP_BRIDGE_EWADJ_STATS_EN adds in_pkt tracking and packet/framing-error counters.

package ptp_bridge_pkg;
    typedef struct packed {
        logic [7:0] src_port;
        logic [7:0] dst_port;
        logic [6:0] bytesvld;
        logic       eop;
        logic       sop;
    } SEGMENT_INFO_S;
endpackage

module ptp_bridge_ewadj
    import ptp_bridge_pkg::*;
#(
    parameter int TDATA_WIDTH        = 512,
    parameter int TKEEP_WIDTH        = TDATA_WIDTH / 8,
    parameter int OUT_WIDTH          = 128,
    parameter int OUT_KEEP_WIDTH     = OUT_WIDTH / 8,
    parameter int USERMETADATA_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic [TDATA_WIDTH-1:0]        s_tdata,
    input  logic [TKEEP_WIDTH-1:0]        s_tkeep,
    input  logic [USERMETADATA_WIDTH-1:0] s_tuser_usermetadata,
    input  SEGMENT_INFO_S                 s_tuser_segment_info,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [OUT_WIDTH-1:0]          m_tdata,
    output logic [OUT_KEEP_WIDTH-1:0]     m_tkeep,
    output logic                          m_tlast,
    output logic [USERMETADATA_WIDTH-1:0] m_tuser_usermetadata,
    output SEGMENT_INFO_S                 m_tuser_segment_info,
    output logic [31:0]                   stat_pkt_cnt,
    output logic [15:0]                   stat_err_cnt
);

    localparam int RATIO = TDATA_WIDTH / OUT_WIDTH;
    localparam int OB    = OUT_KEEP_WIDTH;
    localparam int IW    = $clog2(RATIO);
    localparam int OBW   = $clog2(OB);
    localparam int BW    = $clog2(TKEEP_WIDTH + 1);

    logic [RATIO-1:0][OUT_WIDTH-1:0] word_q;
    SEGMENT_INFO_S                   info_q;
    logic [USERMETADATA_WIDTH-1:0]   meta_q;
    logic                            hold_vld;
    logic [IW-1:0]                   idx;
    logic [IW-1:0]                   last_q;
    logic [OBW:0]                    rem_q;

    logic          s_fire;
    logic          m_fire;
    logic          at_last;
    logic [BW-1:0] in_bytes;
    logic [BW-1:0] bm1;
    logic [IW-1:0] last_in;
    logic [OBW:0]  rem_in;
    logic [OBW:0]  beat_bytes;
    logic [OBW:0]  keep_sh;
    logic          unused_ok;

    assign unused_ok = ^s_tkeep;

    assign at_last  = (idx == last_q);
    assign s_tready = !rst && (!hold_vld || (m_tready && at_last));
    assign s_fire   = s_tvalid && s_tready;
    assign m_fire   = hold_vld && m_tready;

    // Store nbeats-1 and the byte count of the final beat rather than nbeats/bytes.
    always_comb begin
        in_bytes = (s_tuser_segment_info.bytesvld == '0) ? BW'(TKEEP_WIDTH)
                                                         : BW'(s_tuser_segment_info.bytesvld);
        bm1      = in_bytes - BW'(1);
        last_in  = '1;
        rem_in   = (OBW+1)'(OB);
        if (s_tuser_segment_info.eop) begin
            last_in = IW'(bm1 >> OBW);
            rem_in  = {1'b0, bm1[OBW-1:0]} + (OBW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld <= 1'b0;
            idx      <= '0;
        end else if (s_fire) begin
            hold_vld <= 1'b1;
            idx      <= '0;
            word_q   <= s_tdata;
            info_q   <= s_tuser_segment_info;
            meta_q   <= s_tuser_usermetadata;
            last_q   <= last_in;
            rem_q    <= rem_in;
        end else if (m_fire) begin
            if (at_last)
                hold_vld <= 1'b0;
            else
                idx <= idx + IW'(1);
        end
    end

    assign m_tvalid             = hold_vld;
    assign m_tdata              = word_q[idx];
    assign m_tlast              = info_q.eop && at_last;
    assign m_tuser_usermetadata = meta_q;

    // A full beat (OB bytes) encodes as 0 because OB is a power of two.
    always_comb begin
        beat_bytes = at_last ? rem_q : (OBW+1)'(OB);
        keep_sh    = (OBW+1)'(OB) - beat_bytes;
        m_tkeep    = {OUT_KEEP_WIDTH{1'b1}} >> keep_sh;

        m_tuser_segment_info                   = info_q;
        m_tuser_segment_info.sop               = info_q.sop && (idx == '0);
        m_tuser_segment_info.eop               = m_tlast;
        m_tuser_segment_info.bytesvld          = '0;
        m_tuser_segment_info.bytesvld[OBW-1:0] = beat_bytes[OBW-1:0];
    end

`ifdef PTP_BRIDGE_EWADJ_STATS_EN
    logic        in_pkt;
    logic [31:0] pkt_cnt;
    logic [15:0] err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_pkt  <= 1'b0;
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (s_fire) begin
                if ((s_tuser_segment_info.sop && in_pkt) || (!s_tuser_segment_info.sop && !in_pkt))
                    if (err_cnt != '1)
                        err_cnt <= err_cnt + 16'd1;
                if (s_tuser_segment_info.eop)
                    in_pkt <= 1'b0;
                else if (s_tuser_segment_info.sop)
                    in_pkt <= 1'b1;
            end
            if (m_fire && m_tlast && (pkt_cnt != '1))
                pkt_cnt <= pkt_cnt + 32'd1;
        end
    end

    assign stat_pkt_cnt = pkt_cnt;
    assign stat_err_cnt = err_cnt;
`else
    assign stat_pkt_cnt = '0;
    assign stat_err_cnt = '0;
`endif

endmodule

// File: tb/tb_ptp_bridge_ewadj.sv
// Directed self-checking bench for ptp_bridge_ewadj (512 -> 128 bit serialisation).

module tb_ptp_bridge_ewadj;
    import ptp_bridge_pkg::*;

`ifdef PTP_BRIDGE_EWADJ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [511:0]  s_tdata = '0;
    logic [63:0]   s_tkeep = '1;
    logic [0:0]    s_tuser_usermetadata = '0;
    SEGMENT_INFO_S s_tuser_segment_info = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [127:0]  m_tdata;
    logic [15:0]   m_tkeep;
    logic          m_tlast;
    logic [0:0]    m_tuser_usermetadata;
    SEGMENT_INFO_S m_tuser_segment_info;
    logic [31:0]   stat_pkt_cnt;
    logic [15:0]   stat_err_cnt;

    int checks = 0;
    int errors = 0;

    ptp_bridge_ewadj dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tuser_usermetadata(s_tuser_usermetadata), .s_tuser_segment_info(s_tuser_segment_info),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tuser_usermetadata(m_tuser_usermetadata),
        .m_tuser_segment_info(m_tuser_segment_info),
        .stat_pkt_cnt(stat_pkt_cnt), .stat_err_cnt(stat_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [511:0] w, input logic sop, input logic eop, input logic [6:0] bv);
        s_tvalid             = 1'b1;
        s_tdata              = w;
        s_tuser_segment_info = '{src_port: 8'h12, dst_port: 8'h34, bytesvld: bv, eop: eop, sop: sop};
    endtask

    function automatic logic [511:0] mk(input logic [7:0] base);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[i*8 +: 8] = base + 8'(i);
        return r;
    endfunction

    function automatic logic [127:0] sl(input logic [511:0] w, input int i);
        return w[i*128 +: 128];
    endfunction

    logic [511:0] w;
    logic [511:0] p [3];
    logic [127:0] exp_q [12];
    logic [127:0] prev_data;
    logic         prev_stall;
    logic         fired;
    logic         acc;
    int           k;
    int           wi;

    initial begin
        // Reset
        tick(); tick();
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tready", s_tready, 0);

        // Test 1: sop=eop, bytesvld=20 -> 2 beats
        w = mk(8'h00);
        rst = 1'b0;
        drive(w, 1, 1, 7'd20);
        s_tuser_usermetadata = 1'b1;
        #1;
        chk("t1_tready_after_rst", s_tready, 1);
        tick();
        s_tvalid = 1'b0;
        chk("t1_b1_valid", m_tvalid, 1);
        chk("t1_b1_data", m_tdata, sl(w, 0));
        chk("t1_b1_keep", m_tkeep, 16'hFFFF);
        chk("t1_b1_sop", m_tuser_segment_info.sop, 1);
        chk("t1_b1_bvld", m_tuser_segment_info.bytesvld, 0);
        chk("t1_b1_tlast", m_tlast, 0);
        chk("t1_meta", m_tuser_usermetadata, 1);
        chk("t1_port", m_tuser_segment_info.dst_port, 8'h34);
        tick();
        chk("t1_b2_keep", m_tkeep, 16'h000F);
        chk("t1_b2_eop", m_tuser_segment_info.eop, 1);
        chk("t1_b2_tlast", m_tlast, 1);
        chk("t1_b2_bvld", m_tuser_segment_info.bytesvld, 4);
        chk("t1_b2_sop", m_tuser_segment_info.sop, 0);
        chk("t1_b2_bytes", m_tdata[31:0], 32'h13121110);
        tick();
        chk("t1_idle", m_tvalid, 0);

        // Test 2: bytesvld=0 -> 4 full beats
        w = mk(8'h40);
        s_tuser_usermetadata = 1'b0;
        drive(w, 1, 1, 7'd0);
        tick();
        s_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_valid", m_tvalid, 1);
            chk("t2_data", m_tdata, sl(w, i));
            chk("t2_tlast", m_tlast, (i == 3) ? 1 : 0);
            chk("t2_keep", m_tkeep, 16'hFFFF);
            tick();
        end
        chk("t2_idle", m_tvalid, 0);

        // Test 3: 3-word packet, no backpressure
        p[0] = mk(8'h80);
        p[1] = mk(8'hC3);
        p[2] = mk(8'h07);
        drive(p[0], 1, 0, 7'd0);
        tick();
        for (int n = 0; n < 12; n++) begin
            chk("t3_valid", m_tvalid, 1);
            chk("t3_data", m_tdata, sl(p[n/4], n%4));
            chk("t3_tready", s_tready, (n%4 == 3) ? 1 : 0);
            if (n%4 == 3) begin
                if (n/4 < 2) drive(p[n/4+1], 0, (n/4+1) == 2, 7'd0);
                else s_tvalid = 1'b0;
            end
            tick();
        end
        chk("t3_idle", m_tvalid, 0);
        chk("t3_pkt_cnt", stat_pkt_cnt, STATS ? 3 : 0);

        // Test 4: same packet with m_tready toggling
        for (int n = 0; n < 12; n++) exp_q[n] = sl(p[n/4], n%4);
        drive(p[0], 1, 0, 7'd0);
        k = 0;
        wi = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 60 && k < 12; cyc++) begin
            m_tready = (cyc % 2 == 0);
            #1;
            if (prev_stall) chk("t4_hold", m_tdata, prev_data);
            if (m_tvalid) begin
                chk("t4_data", m_tdata, exp_q[k]);
                chk("t4_tlast", m_tlast, (k == 11) ? 1 : 0);
            end
            fired      = m_tvalid && m_tready;
            acc        = s_tvalid && s_tready;
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            tick();
            if (fired) k++;
            if (acc) begin
                wi++;
                if (wi < 3) drive(p[wi], 0, wi == 2, 7'd0);
                else s_tvalid = 1'b0;
            end
        end
        chk("t4_beat_count", k, 12);
        m_tready = 1'b1;
        #1;
        chk("t4_idle", m_tvalid, 0);
        chk("t4_pkt_cnt", stat_pkt_cnt, STATS ? 4 : 0);

        // Test 5: reset during narrow beat 2 of a non-eop word
        w = mk(8'h55);
        drive(w, 1, 0, 7'd0);
        tick();
        s_tvalid = 1'b0;
        chk("t5_b1_data", m_tdata, sl(w, 0));
        tick();
        chk("t5_b2_data", m_tdata, sl(w, 1));
        rst = 1'b1;
        #1;
        chk("t5_tready_in_rst", s_tready, 0);
        tick();
        chk("t5_valid_after_rst", m_tvalid, 0);
        chk("t5_pkt_cnt_rst", stat_pkt_cnt, 0);
        rst = 1'b0;
        #1;
        chk("t5_tready_release", s_tready, 1);
        w = mk(8'hA0);
        drive(w, 1, 1, 7'd16);
        tick();
        s_tvalid = 1'b0;
        chk("t5_new_valid", m_tvalid, 1);
        chk("t5_new_data", m_tdata, sl(w, 0));
        chk("t5_new_sop", m_tuser_segment_info.sop, 1);
        chk("t5_new_tlast", m_tlast, 1);
        chk("t5_new_keep", m_tkeep, 16'hFFFF);
        chk("t5_new_bvld", m_tuser_segment_info.bytesvld, 0);
        tick();
        chk("t5_idle", m_tvalid, 0);

        // Test 6: sop without eop followed by another sop
        p[0] = mk(8'h11);
        p[1] = mk(8'h99);
        drive(p[0], 1, 0, 7'd0);
        tick();
        for (int n = 0; n < 8; n++) begin
            chk("t6_valid", m_tvalid, 1);
            chk("t6_data", m_tdata, sl(p[n/4], n%4));
            if (n == 3) drive(p[1], 1, 1, 7'd0);
            if (n == 4) s_tvalid = 1'b0;
            tick();
        end
        chk("t6_idle", m_tvalid, 0);
        chk("t6_err_cnt", stat_err_cnt, STATS ? 1 : 0);
        chk("t6_pkt_cnt", stat_pkt_cnt, STATS ? 2 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ptp_bridge_ewadj.md
Name: ptp_bridge_ewadj

Overview:
- Egress width adjust stage, directly downstream of the lookup congestion-management stage; one instance per egress interface (DMA, user).
- Accepts wide AXI-S beats (TDATA_WIDTH) carrying ptp_bridge_pkg::SEGMENT_INFO_S sideband.
- Serialises each beat into narrow OUT_WIDTH beats, LSB bytes first, with per-beat tkeep, tlast and rewritten segment info.
- Its s_tready is the ewadj2lu_tready seen by the lookup stage.

Parameters:
TDATA_WIDTH, 512, input data width in bits.
TKEEP_WIDTH, TDATA_WIDTH/8, input bytes per beat.
OUT_WIDTH, 128, output data width; TDATA_WIDTH/OUT_WIDTH is a power of 2, >=2.
OUT_KEEP_WIDTH, OUT_WIDTH/8, output bytes per beat.
USERMETADATA_WIDTH, 1, width of the usermetadata sideband.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_tvalid  in  1  wide beat valid
s_tready  out  1  wide beat accept
s_tdata  in  TDATA_WIDTH  wide data
s_tkeep  in  TKEEP_WIDTH  wide keep; not used, bytesvld is authoritative
s_tuser_usermetadata  in  USERMETADATA_WIDTH  metadata
s_tuser_segment_info  in  SEGMENT_INFO_S  sop/eop/bytesvld/ports
m_tvalid  out  1  narrow beat valid
m_tready  in  1  narrow beat accept
m_tdata  out  OUT_WIDTH  narrow data
m_tkeep  out  OUT_KEEP_WIDTH  narrow keep, contiguous from LSB
m_tlast  out  1  last narrow beat of packet
m_tuser_usermetadata  out  USERMETADATA_WIDTH  held from wide beat
m_tuser_segment_info  out  SEGMENT_INFO_S  rewritten per narrow beat
stat_pkt_cnt  out  32  packets emitted (tlast handshakes)
stat_err_cnt  out  16  framing errors

Behaviour:
- Clock and reset: clock clk; reset rst, synchronous, active-high.
- RATIO = TDATA_WIDTH/OUT_WIDTH; OB = OUT_KEEP_WIDTH.
- Holding register: one wide word, hold_vld flag, beat index idx [log2 RATIO bits], beat total nbeats.
- Load: on s_tvalid & s_tready, capture the word and set hold_vld=1, idx=0.
- nbeats: if eop, bytes = (bytesvld==0 ? TKEEP_WIDTH : bytesvld) and nbeats = ceil(bytes/OB); otherwise nbeats = RATIO.
- s_tready = !rst & (!hold_vld | (m_tready & idx==nbeats-1)). Back-to-back wide beats run with zero bubbles.
- Latency: the first narrow beat is on m_tvalid the cycle after wide acceptance.
- m_tvalid = hold_vld.
- m_tdata = word[idx*OUT_WIDTH +: OUT_WIDTH].
- On m_tvalid & m_tready: if idx==nbeats-1, clear hold_vld (or reload if s_tvalid in the same cycle); otherwise idx++.
- Outputs (all m_* data, tkeep, tuser) are stable while m_tvalid & !m_tready.
- m_tkeep: all ones, except on the final beat of an eop word, where it is '1 >> (OB - rem); rem = bytes - (nbeats-1)*OB, range 1..OB.
- m_tlast = eop & idx==nbeats-1.
- m_tuser_segment_info: copy of the captured info, with these fields rewritten:
  - sop = captured sop & idx==0
  - eop = m_tlast
  - bytesvld = valid bytes in this narrow beat, OB encoded as 0, zero-extended into the field
- Non-eop wide words always emit RATIO full beats; bytesvld on a non-eop word is ignored.
- in_pkt flag: set on an accepted sop without eop; cleared on an accepted eop.
- Framing error, counted only: sop accepted while in_pkt=1, or non-sop accepted while in_pkt=0. Data is forwarded unchanged.
- Counters saturate at all-ones.
- Reset (any time, including mid-packet):
  - hold_vld=0, idx=0, in_pkt=0, counters=0.
  - m_tvalid=0 and s_tready=0 while rst=1; other outputs are don't-care.
  - s_tready=1 in the first cycle after rst deasserts.

Optional Feature:
- PTP_BRIDGE_EWADJ_STATS_EN defined: in_pkt tracking and both counters are implemented as specified.
- Not defined: stat_pkt_cnt and stat_err_cnt are tied to 0, and no counter or in_pkt logic is synthesised. Datapath behaviour is identical in both cases.

Test Plan:
1. Single wide beat sop=eop=1, bytesvld=20, m_tready=1 -> 2 narrow beats:
   - beat 1: m_tkeep=0xFFFF, sop=1, bytesvld=0, tlast=0
   - beat 2: m_tkeep=0x000F, eop=1, tlast=1, bytesvld=4; data = input bytes 16..19
2. Single beat sop=eop=1, bytesvld=0 -> 4 full beats, m_tlast only on the 4th, data slices [127:0],[255:128],[383:256],[511:384].
3. 3-beat packet (last bytesvld=0), s_tvalid and m_tready held 1 -> 12 consecutive m_tvalid cycles with no gap; s_tready high only on the 4th narrow beat of each word; stat_pkt_cnt=1.
4. Same packet with m_tready toggling 1,0,1,0 -> every narrow beat is held stable while stalled; no beat is lost or duplicated; output byte sequence equals input.
5. rst asserted one cycle after accepting a 64-byte non-eop beat, during narrow beat 2 -> m_tvalid=0 next cycle; after release, s_tready=1 and a new sop packet starts at idx 0.
6. With PTP_BRIDGE_EWADJ_STATS_EN, send sop (no eop) then another sop -> stat_err_cnt=1 and both words forwarded intact; without the macro, stat_err_cnt stays 0.
